// File: rtl/tx_string_arb_pkg.sv
// ---------------------------------------------------------------------------
// tx_string_arb_pkg
// Shared types and helpers for the TX_STRING arbiter and its round-robin
// selector.
//   PTR_W       : width of the round-robin pointer / requester index (N <= 8)
//   arb_state_t : one-hot arbiter state encoding
//   ptr_next()  : modulo-N pointer increment
// ---------------------------------------------------------------------------
package tx_string_arb_pkg;

    localparam int PTR_W = 3;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LOAD  = 4'b0010,
        START = 4'b0100,
        BUSY  = 4'b1000
    } arb_state_t;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr,
                                                  input int               n);
        if (int'(ptr) >= n - 1) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/tx_string_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first set request bit at or
// after the pointer, wrapping modulo N.
//   req     : request vector
//   pointer : highest-priority requester index
//   sel     : one-hot winner (zero when no request)
//   index   : binary index of the winner (zero when no request)
//   any     : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
    import tx_string_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] pointer,
    output logic [N-1:0]     sel,
    output logic [PTR_W-1:0] index,
    output logic             any
);

    always_comb begin
        sel   = '0;
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = int'(pointer) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[k]) begin
                any    = 1'b1;
                sel[k] = 1'b1;
                index  = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/tx_string_arbiter.sv
// ---------------------------------------------------------------------------
// tx_string_arbiter
// Shares one TX_STRING engine between N requesters by round-robin. The owner's
// ROM start address is latched, the engine is started with a one-cycle
// tx_string_ready pulse, and a one-cycle done_o pulse is returned to the owner
// when the engine reports completion.
//   clock           : system clock
//   reset           : asynchronous active-low reset
//   req             : level request per requester (held until its done_o)
//   req_addr        : start addresses, requester k at [k*ADDR_W +: ADDR_W]
//   grant           : one-hot owner of the engine, zero when idle
//   done_o          : one-cycle completion pulse to the owner
//   busy            : engine owned by some requester
//   start_addr      : to engine start_addr
//   tx_string_ready : to engine, rising edge starts a string
//   tx_string_done  : from engine, one-cycle completion pulse
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no owner; arbitrate among set req bits
// LOAD  | owner latched; ready held low so the engine sees a stable address
// START | tx_string_ready high for one cycle
// BUSY  | waiting for tx_string_done
// ---------------------------------------------------------------------------
module tx_string_arbiter
    import tx_string_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*ADDR_W-1:0] req_addr,
    output logic [N-1:0]        grant,
    output logic [N-1:0]        done_o,
    output logic                busy,
    output logic [ADDR_W-1:0]   start_addr,
    output logic                tx_string_ready,
    input  logic                tx_string_done
);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [N-1:0]      grant_d;
    logic [N-1:0]      done_d;
    logic              busy_d;
    logic [ADDR_W-1:0] addr_d;
    logic              ready_d;

    logic [N-1:0]      pick_sel;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req     (req),
        .pointer (ptr_q),
        .sel     (pick_sel),
        .index   (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            idx_q           <= '0;
            grant           <= '0;
            done_o          <= '0;
            busy            <= 1'b0;
            start_addr      <= '0;
            tx_string_ready <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            idx_q           <= idx_d;
            grant           <= grant_d;
            done_o          <= done_d;
            busy            <= busy_d;
            start_addr      <= addr_d;
            tx_string_ready <= ready_d;
        end
    end

    // All outputs are registered: the values computed here appear one cycle
    // later, so ready_d is raised while in LOAD to put the pulse in START.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant;
        done_d  = '0;
        busy_d  = busy;
        addr_d  = start_addr;
        ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOAD;
                    grant_d = pick_sel;
                    idx_d   = pick_idx;
                    addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d = START;
                ready_d = 1'b1;
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                // The string cannot be aborted; a dropped req is ignored here.
                if (tx_string_done) begin
                    state_d = IDLE;
                    done_d  = grant;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next(idx_q, N);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_string_arbiter.sv
module tb_tx_string_arbiter;

    localparam int N      = 4;
    localparam int ADDR_W = 8;

    logic                clock;
    logic                reset;
    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N-1:0]        grant;
    logic [N-1:0]        done_o;
    logic                busy;
    logic [ADDR_W-1:0]   start_addr;
    logic                tx_string_ready;
    logic                tx_string_done;

    logic eng_done;
    logic spur_done;
    int   eng_delay;

    assign tx_string_done = eng_done | spur_done;

    tx_string_arbiter #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .req_addr        (req_addr),
        .grant           (grant),
        .done_o          (done_o),
        .busy            (busy),
        .start_addr      (start_addr),
        .tx_string_ready (tx_string_ready),
        .tx_string_done  (tx_string_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]      g;
        logic [ADDR_W-1:0] a;
        int                gap;   // cycles from previous done_o to grant, -1 = don't care
    } gexp_t;

    gexp_t        gq[$];
    logic [N-1:0] dq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic logic [ADDR_W-1:0] addr_of(input int k);
        return ADDR_W'(8'h10 * (k + 1));
    endfunction

    task automatic push_grant(input logic [N-1:0] g, input int k, input int gap);
        gexp_t e;
        e.g   = g;
        e.a   = addr_of(k);
        e.gap = gap;
        gq.push_back(e);
        dq.push_back(g);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: done pulses eng_delay cycles after a ready rising edge.
    initial begin
        logic rdy_prev;
        logic pending;
        int   cnt;
        eng_done = 1'b0;
        rdy_prev = 1'b0;
        pending  = 1'b0;
        cnt      = 0;
        forever begin
            @(negedge clock);
            eng_done = 1'b0;
            if (!reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (cnt <= 1) begin
                        eng_done = 1'b1;
                        pending  = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (tx_string_ready && !rdy_prev) begin
                    pending = 1'b1;
                    cnt     = eng_delay;
                end
            end
            rdy_prev = tx_string_ready;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [N-1:0]      pg;
        logic [ADDR_W-1:0] pa;
        logic              pr;
        int                grant_cyc;
        int                done_cyc;
        int                rdy_cyc;
        gexp_t             e;
        logic [N-1:0]      de;
        pg = '0; pa = '0; pr = 1'b0;
        grant_cyc = -100; done_cyc = -100; rdy_cyc = -100;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                pg = '0; pa = '0; pr = 1'b0;
            end else begin
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                check("done_onehot0", 32'($onehot0(done_o)), 32'd1);
                check("busy_vs_grant", 32'(busy), 32'(grant != '0));
                if (grant != '0 && pg == '0) begin
                    if (gq.size() == 0) begin
                        check("unexpected_grant", 32'(grant), 32'h0);
                    end else begin
                        e = gq.pop_front();
                        check("grant", 32'(grant), 32'(e.g));
                        check("start_addr", 32'(start_addr), 32'(e.a));
                        if (e.gap >= 0) begin
                            check("done_to_grant_gap", 32'(cyc - done_cyc), 32'(e.gap));
                        end
                    end
                    grant_cyc = cyc;
                end else if (grant != '0) begin
                    check("grant_stable", 32'(grant), 32'(pg));
                    check("start_addr_stable", 32'(start_addr), 32'(pa));
                end
                if (tx_string_ready && !pr) begin
                    check("ready_latency", 32'(cyc - grant_cyc), 32'd1);
                    check("ready_low_gap_ok", 32'((cyc - rdy_cyc - 1) >= 2), 32'd1);
                    rdy_cyc = cyc;
                end else if (tx_string_ready && pr) begin
                    check("ready_width", 32'(tx_string_ready), 32'd0);
                end
                if (done_o != '0) begin
                    if (dq.size() == 0) begin
                        check("unexpected_done", 32'(done_o), 32'h0);
                    end else begin
                        de = dq.pop_front();
                        check("done_o", 32'(done_o), 32'(de));
                    end
                    check("grant_clear_at_done", 32'(grant), 32'h0);
                    done_cyc = cyc;
                end
                pg = grant; pa = start_addr; pr = tx_string_ready;
            end
        end
    end

    task automatic wait_done_bit(input int k);
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!done_o[k] && t < 300);
        if (!done_o[k]) begin
            errors++;
            $display("FAIL wait_done[%0d]: timeout after %0d cycles", k, t);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_grant"}, 32'(grant), 32'h0);
        check({name, "_done"}, 32'(done_o), 32'h0);
        check({name, "_busy"}, 32'(busy), 32'h0);
        check({name, "_ready"}, 32'(tx_string_ready), 32'h0);
        check({name, "_start_addr"}, 32'(start_addr), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int t;
        reset     = 1'b0;
        req       = '0;
        spur_done = 1'b0;
        eng_delay = 5;
        for (int k = 0; k < N; k++) req_addr[k*ADDR_W +: ADDR_W] = addr_of(k);
        do_reset();

        // Single request
        push_grant(4'b0010, 1, -1);
        req = 4'b0010;
        @(negedge clock);
        check("single_grant_next_cycle", 32'(grant), 32'h2);
        check("single_addr_next_cycle", 32'(start_addr), 32'h20);
        wait_done_bit(1);
        req[1] = 1'b0;
        @(negedge clock);
        check("single_busy_after", 32'(busy), 32'h0);

        // Contention from pointer 0
        do_reset();
        push_grant(4'b0001, 0, -1);
        push_grant(4'b0010, 1, 1);
        push_grant(4'b0100, 2, 1);
        push_grant(4'b1000, 3, 1);
        push_grant(4'b0001, 0, 1);
        req = 4'b1111;
        wait_done_bit(0);
        wait_done_bit(1);
        wait_done_bit(2);
        wait_done_bit(3);
        wait_done_bit(0);
        req = 4'b0000;
        repeat (3) @(negedge clock);

        // Empty strings, pointer now 1
        eng_delay = 2;
        push_grant(4'b0010, 1, -1);
        push_grant(4'b0100, 2, 1);
        req = 4'b0110;
        wait_done_bit(1);
        req[1] = 1'b0;
        wait_done_bit(2);
        req[2] = 1'b0;
        repeat (3) @(negedge clock);

        // Withdraw during BUSY, address change ignored
        eng_delay = 6;
        push_grant(4'b0100, 2, -1);
        req = 4'b0100;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!tx_string_ready && t < 50);
        check("withdraw_ready_seen", 32'(tx_string_ready), 32'h1);
        req[2] = 1'b0;
        req_addr[2*ADDR_W +: ADDR_W] = 8'hEE;
        wait_done_bit(2);
        req_addr[2*ADDR_W +: ADDR_W] = addr_of(2);
        repeat (2) @(negedge clock);

        // Spurious done in IDLE, pointer stays at 3
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("spurious_grant", 32'(grant), 32'h0);
            check("spurious_done", 32'(done_o), 32'h0);
            check("spurious_busy", 32'(busy), 32'h0);
        end
        push_grant(4'b1000, 3, -1);
        push_grant(4'b0001, 0, 1);
        req = 4'b1001;
        wait_done_bit(3);
        req[3] = 1'b0;
        wait_done_bit(0);
        req[0] = 1'b0;
        repeat (2) @(negedge clock);

        // Reset mid-BUSY, pointer 1 before
        eng_delay = 20;
        gq.push_back('{g: 4'b0100, a: addr_of(2), gap: -1});
        req = 4'b0100;
        repeat (5) @(negedge clock);
        check("midbusy_busy_before", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        req = 4'b0000;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        eng_delay = 3;
        push_grant(4'b0001, 0, -1);
        push_grant(4'b1000, 3, 1);
        req = 4'b1001;
        wait_done_bit(0);
        req[0] = 1'b0;
        wait_done_bit(3);
        req[3] = 1'b0;
        repeat (4) @(negedge clock);

        check("grant_queue_empty", 32'(gq.size()), 32'h0);
        check("done_queue_empty", 32'(dq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
